// File: rtl/cc_bus_pkg.sv
// Crystal Castles CPU bus address map: region limits, I/O slot indices and OUT1 latch bit positions.
package cc_bus_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned SLOT_W     = 3;
  localparam int unsigned OUT1_W     = 8;
  localparam int unsigned OUT1_SEL_W = 3;

  localparam logic [ADDR_W-1:0] SBUS_BASE   = 16'h8000;
  localparam logic [ADDR_W-1:0] SBUS_LIMIT  = 16'h9FFF;
  localparam logic [ADDR_W-1:0] SRAM_BASE   = 16'h8000;
  localparam logic [ADDR_W-1:0] SRAM_LIMIT  = 16'h8FFF;
  localparam logic [ADDR_W-1:0] NVRAM_BASE  = 16'h9000;
  localparam logic [ADDR_W-1:0] NVRAM_LIMIT = 16'h93FF;
  localparam logic [ADDR_W-1:0] IN0_BASE    = 16'h9400;
  localparam logic [ADDR_W-1:0] IN0_LIMIT   = 16'h97FF;
  localparam logic [ADDR_W-1:0] CIO_BASE    = 16'h9800;
  localparam logic [ADDR_W-1:0] CIO_LIMIT   = 16'h9BFF;
  localparam logic [ADDR_W-1:0] IO_BASE     = 16'h9C00;
  localparam logic [ADDR_W-1:0] IO_LIMIT    = 16'h9FFF;
  localparam logic [ADDR_W-1:0] UART_BASE   = 16'h9C00;
  localparam logic [ADDR_W-1:0] UART_LIMIT  = 16'h9C01;
  localparam logic [ADDR_W-1:0] ROM0_BASE   = 16'hA000;
  localparam logic [ADDR_W-1:0] ROM0_LIMIT  = 16'hBFFF;
  localparam logic [ADDR_W-1:0] ROM1_BASE   = 16'hC000;
  localparam logic [ADDR_W-1:0] ROM1_LIMIT  = 16'hDFFF;
  localparam logic [ADDR_W-1:0] ROM2_BASE   = 16'hE000;
  localparam logic [ADDR_W-1:0] ROM2_LIMIT  = 16'hFFFF;

  localparam logic [ADDR_W-1:0] XCOORD_ADDR = 16'h0000;
  localparam logic [ADDR_W-1:0] YCOORD_ADDR = 16'h0001;
  localparam logic [ADDR_W-1:0] BITMD_ADDR  = 16'h0002;

  // 128-byte slots inside 9C00-9FFF, selected by BA[9:7]
  typedef enum logic [SLOT_W-1:0] {
    SLOT_UART   = 3'd0,
    SLOT_HSLD   = 3'd1,
    SLOT_VSLD   = 3'd2,
    SLOT_INTACK = 3'd3,
    SLOT_WDOG   = 3'd4,
    SLOT_OUT0   = 3'd5,
    SLOT_OUT1   = 3'd6,
    SLOT_CRAM   = 3'd7
  } io_slot_e;

  localparam int unsigned OUT1_AX     = 0;
  localparam int unsigned OUT1_AY     = 1;
  localparam int unsigned OUT1_XINC   = 2;
  localparam int unsigned OUT1_YINC   = 3;
  localparam int unsigned OUT1_PLAYER = 4;
  localparam int unsigned OUT1_SIRE   = 5;
  localparam int unsigned OUT1_START  = 6;
  localparam int unsigned OUT1_BUF    = 7;

  function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] limit);
    return (a >= base) && (a <= limit);
  endfunction

endpackage

// File: rtl/cc_addr_latch8.sv
// Generic 8-bit addressable latch (74LS259 style): one bit written per enabled clock, async clear.
module cc_addr_latch8
  import cc_bus_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [OUT1_SEL_W-1:0] addr,
  input  logic                  d,
  output logic [OUT1_W-1:0]     q
);

  logic [OUT1_W-1:0] q_q;
  logic [OUT1_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (we) begin
      q_d[addr] = d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cc_bus_io_decode.sv
// Crystal Castles bus decoder and OUT1 control latch. Define CC_UART_EN to decode the UART at 9C00-9C01.
module cc_bus_io_decode
  import cc_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce2Hd,
  input  logic [ADDR_W-1:0] BA,
  input  logic              BRWn,
  input  logic              BD3,
  output logic              NRn,
  output logic              ROM0n,
  output logic              ROM1n,
  output logic              ROM2n,
  output logic              SBUSn,
  output logic              SRAMn,
  output logic              NVRAMn,
  output logic              IN0n,
  output logic              CIOn,
  output logic              UARTn,
  output logic              HSLDn,
  output logic              VSLDn,
  output logic              INTACKn,
  output logic              WDOGn,
  output logic              OUT0n,
  output logic              OUT1n,
  output logic              CRAMn,
  output logic              XCOORDn,
  output logic              YCOORDn,
  output logic              BITMDn,
  output logic              AXn,
  output logic              AYn,
  output logic              XINCn,
  output logic              YINCn,
  output logic              PLAYER2,
  output logic              SIREn,
  output logic              STARTLED1,
  output logic              BUF1BUF2n
);

  logic              io_hit_c;
  logic              wr_c;
  logic              acc_c;
  io_slot_e          slot_c;
  logic [OUT1_W-1:0] out1_q;

  assign io_hit_c = in_range(BA, IO_BASE, IO_LIMIT);
  assign wr_c     = ~BRWn & ce2Hd;
  assign acc_c    = ce2Hd;
  assign slot_c   = io_slot_e'(BA[9:7]);

  // Memory region selects; NRn is the (active-high) ROM-space flag
  always_comb begin
    NRn    = in_range(BA, ROM0_BASE, ROM2_LIMIT);
    ROM0n  = ~in_range(BA, ROM0_BASE, ROM0_LIMIT);
    ROM1n  = ~in_range(BA, ROM1_BASE, ROM1_LIMIT);
    ROM2n  = ~in_range(BA, ROM2_BASE, ROM2_LIMIT);
    SBUSn  = ~in_range(BA, SBUS_BASE, SBUS_LIMIT);
    SRAMn  = ~in_range(BA, SRAM_BASE, SRAM_LIMIT);
    NVRAMn = ~in_range(BA, NVRAM_BASE, NVRAM_LIMIT);
    IN0n   = ~in_range(BA, IN0_BASE, IN0_LIMIT);
    CIOn   = ~in_range(BA, CIO_BASE, CIO_LIMIT);
  end

  // I/O slot strobes: writes gated by ce2Hd, INTACK/WDOG fire on any qualified access
  always_comb begin
    HSLDn   = 1'b1;
    VSLDn   = 1'b1;
    INTACKn = 1'b1;
    WDOGn   = 1'b1;
    OUT0n   = 1'b1;
    OUT1n   = 1'b1;
    CRAMn   = 1'b1;
    if (io_hit_c) begin
      case (slot_c)
        SLOT_UART:   ;
        SLOT_HSLD:   HSLDn   = ~wr_c;
        SLOT_VSLD:   VSLDn   = ~wr_c;
        SLOT_INTACK: INTACKn = ~acc_c;
        SLOT_WDOG:   WDOGn   = ~acc_c;
        SLOT_OUT0:   OUT0n   = ~wr_c;
        SLOT_OUT1:   OUT1n   = ~wr_c;
        SLOT_CRAM:   CRAMn   = 1'b0;
        default:     ;
      endcase
    end
  end

`ifdef CC_UART_EN
  assign UARTn = ~in_range(BA, UART_BASE, UART_LIMIT);
`else
  assign UARTn = 1'b1;
`endif

  // Bitmode registers live at the bottom of the zero page
  always_comb begin
    XCOORDn = ~((BA == XCOORD_ADDR) & wr_c);
    YCOORDn = ~((BA == YCOORD_ADDR) & wr_c);
    BITMDn  = ~(BA == BITMD_ADDR);
  end

  cc_addr_latch8 u_out1 (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (~OUT1n),
    .addr    (BA[OUT1_SEL_W-1:0]),
    .d       (BD3),
    .q       (out1_q)
  );

  assign AXn       = out1_q[OUT1_AX];
  assign AYn       = out1_q[OUT1_AY];
  assign XINCn     = out1_q[OUT1_XINC];
  assign YINCn     = out1_q[OUT1_YINC];
  assign PLAYER2   = out1_q[OUT1_PLAYER];
  assign SIREn     = out1_q[OUT1_SIRE];
  assign STARTLED1 = out1_q[OUT1_START];
  assign BUF1BUF2n = out1_q[OUT1_BUF];

endmodule

// File: tb/tb_cc_bus_io_decode.sv
// Directed bench for cc_bus_io_decode: address sweep, strobe qualification, OUT1 latch and bitmode regs.
module tb_cc_bus_io_decode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce2Hd;
  logic [15:0] BA;
  logic        BRWn;
  logic        BD3;
  logic NRn, ROM0n, ROM1n, ROM2n, SBUSn, SRAMn, NVRAMn, IN0n, CIOn, UARTn;
  logic HSLDn, VSLDn, INTACKn, WDOGn, OUT0n, OUT1n, CRAMn;
  logic XCOORDn, YCOORDn, BITMDn;
  logic AXn, AYn, XINCn, YINCn, PLAYER2, SIREn, STARTLED1, BUF1BUF2n;

  int errors = 0;
  int checks = 0;

  always #50 clk = ~clk;

  cc_bus_io_decode dut (
    .clk(clk), .reset_n(reset_n), .ce2Hd(ce2Hd), .BA(BA), .BRWn(BRWn), .BD3(BD3),
    .NRn(NRn), .ROM0n(ROM0n), .ROM1n(ROM1n), .ROM2n(ROM2n), .SBUSn(SBUSn),
    .SRAMn(SRAMn), .NVRAMn(NVRAMn), .IN0n(IN0n), .CIOn(CIOn), .UARTn(UARTn),
    .HSLDn(HSLDn), .VSLDn(VSLDn), .INTACKn(INTACKn), .WDOGn(WDOGn),
    .OUT0n(OUT0n), .OUT1n(OUT1n), .CRAMn(CRAMn),
    .XCOORDn(XCOORDn), .YCOORDn(YCOORDn), .BITMDn(BITMDn),
    .AXn(AXn), .AYn(AYn), .XINCn(XINCn), .YINCn(YINCn), .PLAYER2(PLAYER2),
    .SIREn(SIREn), .STARTLED1(STARTLED1), .BUF1BUF2n(BUF1BUF2n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one bus cycle at the falling edge; the next rising edge is the one that latches
  task automatic bus(input logic [15:0] a, input logic rw, input logic ce, input logic d);
    @(negedge clk);
    BA = a; BRWn = rw; ce2Hd = ce; BD3 = d;
    #1;
  endtask

  function automatic logic [6:0] mem_sel();
    return {SRAMn, NVRAMn, IN0n, CIOn, ROM0n, ROM1n, ROM2n};
  endfunction

  function automatic logic [6:0] io_sel();
    return {HSLDn, VSLDn, INTACKn, WDOGn, OUT0n, OUT1n, CRAMn};
  endfunction

  function automatic logic [7:0] out1();
    return {BUF1BUF2n, STARTLED1, SIREn, PLAYER2, YINCn, XINCn, AYn, AXn};
  endfunction

  logic [15:0] sweep_a [10] = '{16'h8000, 16'h8FFF, 16'h9000, 16'h93FF, 16'h9400,
                                16'h9800, 16'h9BFF, 16'hA000, 16'hC000, 16'hE000};
  logic [6:0]  sweep_e [10] = '{7'b0111111, 7'b0111111, 7'b1011111, 7'b1011111, 7'b1101111,
                                7'b1110111, 7'b1110111, 7'b1111011, 7'b1111101, 7'b1111110};

  initial begin
    reset_n = 1'b0; ce2Hd = 1'b0; BA = 16'h0002; BRWn = 1'b1; BD3 = 1'b0;
    #20;
    check("rst_out1", 32'(out1()), 32'h00);
    check("rst_bitmd_comb", 32'(BITMDn), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Region sweep: one memory select, SBUS umbrella below A000, NRn flag at/above A000
    for (int i = 0; i < 10; i++) begin
      bus(sweep_a[i], 1'b1, 1'b1, 1'b0);
      check($sformatf("sweep_sel_%h", sweep_a[i]), 32'(mem_sel()), 32'(sweep_e[i]));
      check($sformatf("sweep_sbus_%h", sweep_a[i]), 32'(SBUSn), (sweep_a[i] >= 16'hA000) ? 32'd1 : 32'd0);
      check($sformatf("sweep_nr_%h", sweep_a[i]), 32'(NRn), (sweep_a[i] >= 16'hA000) ? 32'd1 : 32'd0);
      check($sformatf("sweep_io_%h", sweep_a[i]), 32'(io_sel()), 32'h7F);
    end

    // HSLD write strobe qualification
    bus(16'h9C80, 1'b0, 1'b1, 1'b0);
    check("hsld_wr", 32'(io_sel()), 32'b0111111);
    bus(16'h9C80, 1'b0, 1'b0, 1'b0);
    check("hsld_no_ce", 32'(HSLDn), 32'd1);
    bus(16'h9C80, 1'b1, 1'b1, 1'b0);
    check("hsld_read", 32'(HSLDn), 32'd1);
    bus(16'h9D00, 1'b0, 1'b1, 1'b0);
    check("vsld_wr", 32'(io_sel()), 32'b1011111);
    bus(16'h9E80, 1'b0, 1'b1, 1'b0);
    check("out0_wr", 32'(io_sel()), 32'b1111011);

    // INTACK / WDOG respond to reads
    bus(16'h9D80, 1'b1, 1'b1, 1'b0);
    check("intack_rd", 32'(io_sel()), 32'b1101111);
    bus(16'h9D80, 1'b1, 1'b0, 1'b0);
    check("intack_idle", 32'(INTACKn), 32'd1);
    bus(16'h9E00, 1'b1, 1'b1, 1'b0);
    check("wdog_rd", 32'(io_sel()), 32'b1110111);
    bus(16'h9F80, 1'b1, 1'b0, 1'b0);
    check("cram_sel", 32'(io_sel()), 32'b1111110);

    // OUT1 latch: one bit per write, mirrors through BA[6:3]
    bus(16'h9F04, 1'b0, 1'b1, 1'b1);
    check("out1_strobe", 32'(OUT1n), 32'd0);
    bus(16'h0003, 1'b1, 1'b0, 1'b0);
    check("out1_player2", 32'(out1()), 32'h10);
    bus(16'h9F4F, 1'b0, 1'b1, 1'b1);
    bus(16'h0003, 1'b1, 1'b0, 1'b0);
    check("out1_mirror_buf", 32'(out1()), 32'h90);
    bus(16'h9F00, 1'b0, 1'b0, 1'b1);
    bus(16'h0003, 1'b1, 1'b0, 1'b0);
    check("out1_no_ce", 32'(out1()), 32'h90);
    bus(16'h9F04, 1'b0, 1'b1, 1'b0);
    bus(16'h9F7A, 1'b0, 1'b1, 1'b1);
    bus(16'h0003, 1'b1, 1'b0, 1'b0);
    check("out1_clr_set", 32'(out1()), 32'h84);
    bus(16'h9F01, 1'b1, 1'b1, 1'b1);
    bus(16'h0003, 1'b1, 1'b0, 1'b0);
    check("out1_read_ignored", 32'(out1()), 32'h84);

    // Asynchronous clear while a write is in flight
    bus(16'h9F00, 1'b0, 1'b1, 1'b1);
    reset_n = 1'b0;
    #1;
    check("out1_async_rst", 32'(out1()), 32'h00);
    check("rst_no_effect_sel", 32'(OUT1n), 32'd0);
    @(posedge clk);
    #1;
    check("out1_held_in_rst", 32'(out1()), 32'h00);
    reset_n = 1'b1;

    // Bitmode registers
    bus(16'h0000, 1'b0, 1'b1, 1'b0);
    check("bm_0000", 32'({XCOORDn, YCOORDn, BITMDn}), 32'b011);
    bus(16'h0001, 1'b0, 1'b1, 1'b0);
    check("bm_0001", 32'({XCOORDn, YCOORDn, BITMDn}), 32'b101);
    bus(16'h0002, 1'b0, 1'b1, 1'b0);
    check("bm_0002", 32'({XCOORDn, YCOORDn, BITMDn}), 32'b110);
    bus(16'h0003, 1'b0, 1'b1, 1'b0);
    check("bm_0003", 32'({XCOORDn, YCOORDn, BITMDn}), 32'b111);
    check("bm_0003_mem", 32'({mem_sel(), SBUSn, NRn, UARTn}), 32'b1111111_1_0_1);
    bus(16'h0000, 1'b0, 1'b0, 1'b0);
    check("bm_xcoord_no_ce", 32'(XCOORDn), 32'd1);
    bus(16'h0002, 1'b1, 1'b0, 1'b0);
    check("bm_bitmd_ungated", 32'(BITMDn), 32'd0);

    // UART slot
    bus(16'h9C01, 1'b1, 1'b0, 1'b0);
`ifdef CC_UART_EN
    check("uart_9c01", 32'(UARTn), 32'd0);
`else
    check("uart_9c01", 32'(UARTn), 32'd1);
`endif
    check("uart_slot_io", 32'(io_sel()), 32'h7F);
    bus(16'h9C02, 1'b0, 1'b1, 1'b0);
    check("uart_9c02", 32'({UARTn, io_sel()}), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
